// File: rtl/sprot_tx.sv
// sprot_tx: transmitter side of the start/a/b wire protocol.
//
// Accepts a request on a valid/ready handshake and drives start, a and b on
// three consecutive cycles. The a or b phase may be suppressed on request
// for error injection. It then waits for the receiver's xfer_end/prot_err
// response (or times out), reports the outcome with a done pulse and keeps
// saturating transfer/error counters. All outputs are registered.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_err[1:0]      bit0 suppresses a, bit1 suppresses b; latched on accept
//   start, a, b       protocol pulses
//   xfer_end,prot_err receiver response
//   done              one-cycle outcome pulse; done_err/mismatch/timeout qualify it
//   xfer_cnt,err_cnt  saturating status counters
module sprot_tx #(
  parameter int GAP_CYCLES   = 1,
  parameter int RESP_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_err,
  output logic             start,
  output logic             a,
  output logic             b,
  input  logic             xfer_end,
  input  logic             prot_err,
  output logic             done,
  output logic             done_err,
  output logic             mismatch,
  output logic             timeout,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Timer holds the number of response cycles still left after the current one.
  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ST_START,
    ST_A,
    ST_B,
    WAIT_RESP,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [1:0]    err_q, err_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          start_n, a_n, b_n;
  logic          done_n, done_err_n, mismatch_n, timeout_n;

  always_comb begin
    state_n    = state;
    err_n      = err_q;
    tmr_n      = tmr;
    gcnt_n     = gcnt;
    start_n    = 1'b0;
    a_n        = 1'b0;
    b_n        = 1'b0;
    done_n     = 1'b0;
    done_err_n = 1'b0;
    mismatch_n = 1'b0;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          err_n   = req_err;
          start_n = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        a_n     = ~err_q[0];
        state_n = ST_A;
      end
      ST_A: begin
        b_n     = ~err_q[1];
        tmr_n   = TW'(RESP_TIMEOUT - 1);
        state_n = ST_B;
      end
      // The b cycle is cycle 0 of the response window, so it samples
      // xfer_end exactly like the WAIT_RESP cycles that follow it. A
      // response in the final window cycle wins over the timeout.
      ST_B, WAIT_RESP: begin
        if (xfer_end) begin
          done_n     = 1'b1;
          done_err_n = prot_err;
          mismatch_n = prot_err != (err_q != 2'b00);
        end else if (tmr == '0) begin
          done_n     = 1'b1;
          done_err_n = 1'b1;
          timeout_n  = 1'b1;
        end else begin
          tmr_n   = tmr - 1'b1;
          state_n = WAIT_RESP;
        end
        // The done cycle is the first gap cycle; with no gap it is already idle.
        if (done_n) begin
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            gcnt_n  = GW'(GAP_CYCLES - 1);
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (gcnt == '0) state_n = IDLE;
        else            gcnt_n  = gcnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err_q    <= 2'b00;
      tmr      <= '0;
      gcnt     <= '0;
      req_ready <= 1'b0;
      start    <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
      mismatch <= 1'b0;
      timeout  <= 1'b0;
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      err_q    <= err_n;
      tmr      <= tmr_n;
      gcnt     <= gcnt_n;
      req_ready <= (state_n == IDLE);
      start    <= start_n;
      a        <= a_n;
      b        <= b_n;
      done     <= done_n;
      done_err <= done_err_n;
      mismatch <= mismatch_n;
      timeout  <= timeout_n;
      // Counters update with the done pulse so they already include it.
      if (done_n && (xfer_cnt != '1))
        xfer_cnt <= xfer_cnt + 1'b1;
      if (done_n && (mismatch_n || timeout_n) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/sprot_tx.md
Name: sprot_tx

Overview:
Transmitter side of the simple start/a/b protocol. It accepts transfer requests over a valid/ready handshake and drives the single-cycle wire sequence: start, then a one cycle later, then b one cycle after that. It can deliberately corrupt the a or b phase for error injection. It then waits for the receiver's xfer_end/prot_err response, checks it against the expected outcome, and keeps saturating transfer and error counters.

Parameters:
GAP_CYCLES, 1, minimum idle cycles between the end of one transfer and the next req_ready (0 allowed)
RESP_TIMEOUT, 8, cycles after the b cycle to wait for xfer_end before flagging a timeout (>=1)
CNT_W, 8, width of the saturating status counters

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  1  transfer request
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready at a posedge
req_err  input  2  sampled on accept: 00 clean, 01 drop a, 10 drop b, 11 drop both
start  output  1  protocol start pulse
a  output  1  protocol phase-a pulse
b  output  1  protocol phase-b pulse
xfer_end  input  1  receiver end-of-transfer indication
prot_err  input  1  receiver error flag, valid when xfer_end=1
done  output  1  one-cycle pulse when a response is received or a timeout occurs
done_err  output  1  valid with done: prot_err as received (1 on timeout)
mismatch  output  1  valid with done: received prot_err differs from expected (expected = req_err!=00)
timeout  output  1  valid with done: no xfer_end within RESP_TIMEOUT
xfer_cnt  output  CNT_W  completed transfers (done pulses), saturating
err_cnt  output  CNT_W  done pulses with mismatch or timeout, saturating

Behaviour:
- All outputs are registered. Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. start/a/b/done/done_err/mismatch/timeout=0. Counters=0. State=IDLE. Latched req_err=00.
- FSM states: IDLE, ST_START, ST_A, ST_B, WAIT_RESP, GAP.
- IDLE: req_ready=1. On accept, latch req_err and go to ST_START. start=1 in the cycle after the accept edge.
- ST_START: start=1 for exactly one cycle. Next state is ST_A.
- ST_A: a = ~req_err[0] for one cycle. Next state is ST_B.
- ST_B: b = ~req_err[1] for one cycle. Next state is WAIT_RESP; load the timeout counter with RESP_TIMEOUT.
- Wire contract: start at cycle N, a at N+1, b at N+2. There are never overlapping pulses. start is never reasserted before GAP completes.
- WAIT_RESP: sample xfer_end each cycle; the b cycle itself counts as cycle 0.
  - xfer_end=1 sampled: next cycle done=1, done_err=prot_err, mismatch=(prot_err != (req_err!=00)), timeout=0. Go to GAP.
  - Counter expires without xfer_end: done=1, done_err=1, timeout=1, mismatch=0. Go to GAP.
  - xfer_end seen in the expiry cycle: treat as a response, not a timeout.
  - xfer_end outside WAIT_RESP is ignored.
- GAP: stay GAP_CYCLES cycles with req_ready=0, then go to IDLE. With GAP_CYCLES=0, go directly from the done cycle to IDLE, so the next accept is possible in the cycle done is high.
- Counters: xfer_cnt increments on every done. err_cnt increments on done when (mismatch || timeout). Both hold at 2^CNT_W-1.
- rst asserted in any state (including mid-sequence): at the next edge, all pulses drop to 0 and the state returns to IDLE. Counters clear. No done is generated for the aborted transfer.
- Throughput: minimum request-to-request period = 3 (sequence) + response latency + 1 (done) + GAP_CYCLES.

Test Plan:
- Clean transfer, defaults; receiver answers xfer_end=1, prot_err=0 two cycles after b -> start/a/b at N, N+1, N+2; one done with done_err=0, mismatch=0; xfer_cnt=1, err_cnt=0.
- req_err=01, receiver returns prot_err=1 -> a stays 0 at N+1, b=1 at N+2; done_err=1, mismatch=0, err_cnt=0.
- req_err=10, receiver wrongly returns prot_err=0 -> b=0 at N+2; mismatch=1; err_cnt=1.
- No xfer_end, RESP_TIMEOUT=8 -> done and timeout=1 exactly 8 cycles after the b cycle, done_err=1; err_cnt=1. With xfer_end in the expiry cycle instead -> timeout=0.
- req_valid held high, GAP_CYCLES=2 -> start pulses separated by exactly 3+latency+1+2 cycles; req_ready low through GAP. Repeat with GAP_CYCLES=0 -> accept occurs in the done cycle.
- rst pulsed the cycle a is high -> b never asserts, no done, counters 0, req_ready=1 the cycle after rst deasserts. Separately, CNT_W=2 with 5 mismatched transfers -> xfer_cnt=3, err_cnt=3 (saturated).
